vrf_addr_seq: RTL and testbench

- Per-lane vector register file address sequencer; successor to the lane's free-running address counter.
- Generates one VRF word address per element, with a sub-word byte select, for a bounded element count (vl).
- Walks a configurable number of register groups (LMUL) in ascending or descending order, with a wrap-safe slide offset.
- Uses a valid/ready handshake to the VRF read/write port, and signals completion with a done pulse.

---
 rtl/vrf_addr_seq_pkg.sv | 29 ++
 rtl/vrf_elem_cnt.sv | 45 ++++
 rtl/vrf_addr_seq.sv | 187 ++++++++++++++++++
 tb/tb_vrf_addr_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vrf_addr_seq_pkg.sv
// Shared vector-core types and helpers for the VRF address sequencer.
// Covers element widths, sequencer states and the elements-per-group computation.
package vrf_addr_seq_pkg;

  typedef enum logic [1:0] {
    SEW8    = 2'd0,
    SEW16   = 2'd1,
    SEW32   = 2'd2,
    SEW_RSV = 2'd3
  } sew_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  localparam int MIN_SEW   = 8;
  localparam int WORD_BITS = 32;

  // Elements held by one register group in one lane; zero for the reserved width.
  function automatic int unsigned elems_per_group(input sew_e sew, input int unsigned vloc);
    if (sew == SEW_RSV) begin
      return 0;
    end
    return vloc * $unsigned(WORD_BITS / (MIN_SEW << sew));
  endfunction

endpackage

// File: rtl/vrf_elem_cnt.sv
// Bidirectional element counter with a chained group pointer.
// The element counter wraps modulo E; each wrap steps the group pointer.
module vrf_elem_cnt #(
  parameter int CW = 5,
  parameter int GW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          up,
  input  logic [CW-1:0] e_max,
  input  logic [GW-1:0] g_max,
  input  logic          advance,
  output logic [CW-1:0] c,
  output logic [GW-1:0] g
);

  logic          up_reg;
  logic [CW-1:0] e_max_reg;
  logic          wrap;

  assign wrap = up_reg ? (c == e_max_reg) : (c == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_reg    <= 1'b0;
      e_max_reg <= '0;
      c         <= '0;
      g         <= '0;
    end else if (load) begin
      up_reg    <= up;
      e_max_reg <= e_max;
      c         <= up ? '0 : e_max;
      g         <= up ? '0 : g_max;
    end else if (advance) begin
      if (wrap) begin
        c <= up_reg ? '0 : e_max_reg;
        g <= up_reg ? g + 1'b1 : g - 1'b1;
      end else begin
        c <= up_reg ? c + 1'b1 : c - 1'b1;
      end
    end
  end

endmodule

// File: rtl/vrf_addr_seq.sv
// Per-lane VRF address sequencer: walks vl elements across LMUL register groups,
// producing word address plus byte select over a valid/ready handshake.
module vrf_addr_seq
  import vrf_addr_seq_pkg::*;
#(
  parameter int MEM_DEPTH         = 512,
  parameter int VREG_LOC_PER_LANE = 8,
  parameter int MAX_GROUP         = 8,
  parameter int VL_W              = 12,
  localparam int AW               = $clog2(MEM_DEPTH),
  localparam int GW               = $clog2(MAX_GROUP) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    flush_i,
  input  logic [MAX_GROUP*AW-1:0] start_addr_i,
  input  logic [GW-1:0]           group_cnt_i,
  input  logic [AW-1:0]           slide_offset_i,
  input  logic                    up_down_i,
  input  logic [1:0]              element_width_i,
  input  logic [VL_W-1:0]         vl_i,
  input  logic                    ready_i,
  output logic                    valid_o,
  output logic [AW-1:0]           addr_o,
  output logic [1:0]              byte_sel_o,
  output logic                    last_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int CW = $clog2(VREG_LOC_PER_LANE * (WORD_BITS / MIN_SEW));
  localparam int NG = 2 ** GW;
  localparam logic [GW-1:0] GC_MAX = GW'(MAX_GROUP);

  seq_state_e state_reg, state_next;

  logic [MAX_GROUP*AW-1:0] base_reg;
  logic [AW-1:0]           offset_reg;
  logic                    up_reg;
  sew_e                    sew_reg;
  logic [VL_W-1:0]         rem_reg;

  sew_e            sew_in;
  logic [GW-1:0]   gc_eff;
  logic [31:0]     e_in;
  logic [31:0]     total_in;
  logic [VL_W-1:0] n_in;
  logic [CW-1:0]   e_max_in;
  logic [GW-1:0]   g_max_in;
  logic            load;
  logic            accept;
  logic            run;

  logic [CW-1:0] c;
  logic [GW-1:0] g;
  logic [CW-1:0] word_idx;
  logic [AW-1:0] addr_sum;
  logic [AW-1:0] addr_calc;
  logic [1:0]    bs_calc;
  logic [AW-1:0] base_arr [NG];

  // Pointer values past the configured groups read as zero instead of going out of range.
  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_base
      if (gi < MAX_GROUP) begin : g_used
        assign base_arr[gi] = base_reg[gi*AW +: AW];
      end else begin : g_pad
        assign base_arr[gi] = '0;
      end
    end
  endgenerate

  assign sew_in = sew_e'(element_width_i);

  always_comb begin
    gc_eff = group_cnt_i;
    if (group_cnt_i == '0) begin
      gc_eff = GW'(1);
    end else if (group_cnt_i > GC_MAX) begin
      gc_eff = GC_MAX;
    end
  end

  assign e_in     = elems_per_group(sew_in, $unsigned(VREG_LOC_PER_LANE));
  assign total_in = 32'(gc_eff) * e_in;
  assign n_in     = (32'(vl_i) < total_in) ? vl_i : VL_W'(total_in);
  assign e_max_in = CW'(e_in - 32'd1);
  assign g_max_in = gc_eff - GW'(1);

  assign load   = (state_reg == IDLE) && start_i && !flush_i;
  assign accept = (state_reg == RUN) && ready_i && !flush_i;
  assign run    = (state_reg == RUN);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (load) begin
          state_next = (n_in == '0 || sew_in == SEW_RSV) ? DONE : RUN;
        end
      end
      RUN: begin
        if (flush_i) begin
          state_next = IDLE;
        end else if (accept && rem_reg == VL_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      base_reg   <= '0;
      offset_reg <= '0;
      up_reg     <= 1'b0;
      sew_reg    <= SEW8;
      rem_reg    <= '0;
    end else if (load) begin
      base_reg   <= start_addr_i;
      offset_reg <= slide_offset_i;
      up_reg     <= up_down_i;
      sew_reg    <= sew_in;
      rem_reg    <= n_in;
    end else if (accept) begin
      rem_reg <= rem_reg - VL_W'(1);
    end
  end

  vrf_elem_cnt #(
    .CW(CW),
    .GW(GW)
  ) u_cnt (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .load   (load),
    .up     (up_down_i),
    .e_max  (e_max_in),
    .g_max  (g_max_in),
    .advance(accept),
    .c      (c),
    .g      (g)
  );

  // Narrower elements pack several per word: the word index drops the byte-lane bits.
  always_comb begin
    word_idx = c;
    bs_calc  = 2'b00;
    case (sew_reg)
      SEW8: begin
        word_idx = c >> 2;
        bs_calc  = c[1:0];
      end
      SEW16: begin
        word_idx = c >> 1;
        bs_calc  = {c[0], 1'b0};
      end
      default: begin
        word_idx = c;
        bs_calc  = 2'b00;
      end
    endcase
  end

  assign addr_sum  = base_arr[g] + {{(AW-CW){1'b0}}, word_idx};
  assign addr_calc = up_reg ? addr_sum + offset_reg : addr_sum - offset_reg;

  assign valid_o    = run;
  assign addr_o     = run ? addr_calc : '0;
  assign byte_sel_o = run ? bs_calc : 2'b00;
  assign last_o     = run && (rem_reg == VL_W'(1));
  assign busy_o     = (state_reg != IDLE);
  assign done_o     = (state_reg == DONE);

endmodule

// File: tb/tb_vrf_addr_seq.sv
// Directed bench for vrf_addr_seq: ascending/descending walks, wrap, clamp,
// backpressure, empty runs, flush and asynchronous reset.
module tb_vrf_addr_seq;

  localparam int AW = 9;
  localparam int GW = 4;

  logic          clk;
  logic          rst_i;
  logic          start_i;
  logic          flush_i;
  logic [8*AW-1:0] start_addr_i;
  logic [GW-1:0] group_cnt_i;
  logic [AW-1:0] slide_offset_i;
  logic          up_down_i;
  logic [1:0]    element_width_i;
  logic [11:0]   vl_i;
  logic          ready_i;
  logic          valid_o;
  logic [AW-1:0] addr_o;
  logic [1:0]    byte_sel_o;
  logic          last_o;
  logic          busy_o;
  logic          done_o;

  int checks = 0;
  int errors = 0;

  vrf_addr_seq dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .flush_i        (flush_i),
    .start_addr_i   (start_addr_i),
    .group_cnt_i    (group_cnt_i),
    .slide_offset_i (slide_offset_i),
    .up_down_i      (up_down_i),
    .element_width_i(element_width_i),
    .vl_i           (vl_i),
    .ready_i        (ready_i),
    .valid_o        (valid_o),
    .addr_o         (addr_o),
    .byte_sel_o     (byte_sel_o),
    .last_o         (last_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_base(input int g, input logic [AW-1:0] a);
    start_addr_i[g*AW +: AW] = a;
  endtask

  task automatic cfg(input logic up, input logic [1:0] ew, input logic [GW-1:0] gc,
                     input logic [AW-1:0] off, input logic [11:0] vl);
    up_down_i       = up;
    element_width_i = ew;
    group_cnt_i     = gc;
    slide_offset_i  = off;
    vl_i            = vl;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Checks one beat with ready_i high, then advances a cycle.
  task automatic beat(input string tag, input int i, input logic [AW-1:0] ea,
                      input logic [1:0] eb, input logic el);
    chk($sformatf("%s_valid%0d", tag, i), 32'(valid_o), 32'd1);
    chk($sformatf("%s_addr%0d", tag, i), 32'(addr_o), 32'(ea));
    chk($sformatf("%s_bsel%0d", tag, i), 32'(byte_sel_o), 32'(eb));
    chk($sformatf("%s_last%0d", tag, i), 32'(last_o), 32'(el));
    $display("beat %s #%0d addr=0x%03h bsel=%0d last=%0b", tag, i, addr_o, byte_sel_o, last_o);
    tick();
  endtask

  initial begin
    int b;
    int dc;
    int dn;
    logic done_seen;
    logic [3:0] pat;

    rst_i = 1'b0; start_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
    start_addr_i = '0;
    cfg(1'b1, 2'b00, 4'd1, 9'd0, 12'd0);
    tick(); tick();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_addr", 32'(addr_o), 32'd0);
    chk("rst_bsel", 32'(byte_sel_o), 32'd0);
    chk("rst_last", 32'(last_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    rst_i = 1'b1;
    tick();

    // Ascending 32b across two groups; a start mid-run must be ignored.
    ready_i = 1'b1;
    set_base(0, 9'h010); set_base(1, 9'h040);
    cfg(1'b1, 2'b10, 4'd2, 9'd0, 12'd16);
    do_start();
    chk("t1_latency_valid", 32'(valid_o), 32'd1);
    for (int i = 0; i < 16; i++) begin
      start_i = (i == 5);
      if (i == 5) begin
        slide_offset_i = 9'd7;
        vl_i = 12'd2;
      end
      beat("t1", i, (i < 8) ? 9'(9'h010 + i) : 9'(9'h040 + i - 8), 2'd0, i == 15);
    end
    start_i = 1'b0;
    chk("t1_done", 32'(done_o), 32'd1);
    chk("t1_done_valid", 32'(valid_o), 32'd0);
    tick();
    chk("t1_done_pulse", 32'(done_o), 32'd0);
    chk("t1_idle_busy", 32'(busy_o), 32'd0);

    // Descending 8b, one group, offset subtracted; start during done is ignored.
    set_base(0, 9'h100);
    cfg(1'b0, 2'b00, 4'd1, 9'd3, 12'd5);
    do_start();
    for (int i = 0; i < 5; i++) begin
      beat("t2", i, (i < 4) ? 9'h104 : 9'h103, (i < 4) ? 2'(3 - i) : 2'd3, i == 4);
    end
    chk("t2_done", 32'(done_o), 32'd1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("t2_b2b_busy", 32'(busy_o), 32'd0);
    chk("t2_b2b_valid", 32'(valid_o), 32'd0);

    // Ascending 16b with address wrap and vl clamped to 16.
    set_base(0, 9'h1FE);
    cfg(1'b1, 2'b01, 4'd1, 9'd4, 12'd40);
    do_start();
    chk("t3_first_addr", 32'(addr_o), 32'h002);
    for (int i = 0; i < 16; i++) begin
      beat("t3", i, 9'(9'h1FE + 9'(i >> 1) + 9'd4), (i % 2 == 1) ? 2'd2 : 2'd0, i == 15);
    end
    chk("t3_done", 32'(done_o), 32'd1);
    tick();

    // Backpressure with ready pattern 1,0,0,1.
    set_base(0, 9'h020);
    cfg(1'b1, 2'b10, 4'd1, 9'd0, 12'd3);
    pat = 4'b1001;
    b = 0;
    done_seen = 1'b0;
    do_start();
    for (int cyc = 0; cyc < 40; cyc++) begin
      ready_i = pat[cyc % 4];
      if (done_o) begin
        done_seen = 1'b1;
        break;
      end
      if (valid_o) begin
        chk($sformatf("t4_addr_c%0d", cyc), 32'(addr_o), 32'(9'h020 + 9'(b)));
        chk($sformatf("t4_bsel_c%0d", cyc), 32'(byte_sel_o), 32'd0);
        chk($sformatf("t4_last_c%0d", cyc), 32'(last_o), 32'(b == 2));
        $display("bp cyc %0d addr=0x%03h ready=%0b last=%0b", cyc, addr_o, ready_i, last_o);
        if (ready_i) b++;
      end
      tick();
    end
    chk("t4_beats", 32'(b), 32'd3);
    chk("t4_done_seen", 32'(done_seen), 32'd1);
    ready_i = 1'b1;
    tick();
    chk("t4_idle", 32'(busy_o), 32'd0);

    // Empty runs: vl=0, then reserved element width.
    for (int t = 0; t < 2; t++) begin
      if (t == 0) cfg(1'b1, 2'b10, 4'd1, 9'd0, 12'd0);
      else        cfg(1'b1, 2'b11, 4'd1, 9'd0, 12'd5);
      do_start();
      dc = -1;
      dn = 0;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("t5_%0d_valid%0d", t, k), 32'(valid_o), 32'd0);
        if (done_o) begin
          dn++;
          if (dc < 0) dc = k;
        end
        tick();
      end
      $display("empty run %0d done at offset %0d", t, dc);
      chk($sformatf("t5_%0d_done_in_time", t), 32'(dc == 0 || dc == 1), 32'd1);
      chk($sformatf("t5_%0d_done_count", t), 32'(dn), 32'd1);
    end

    // Flush on the third beat.
    set_base(0, 9'h010); set_base(1, 9'h040);
    cfg(1'b1, 2'b10, 4'd2, 9'd0, 12'd16);
    do_start();
    beat("t6", 0, 9'h010, 2'd0, 1'b0);
    beat("t6", 1, 9'h011, 2'd0, 1'b0);
    chk("t6_third_valid", 32'(valid_o), 32'd1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("t6_flush_valid", 32'(valid_o), 32'd0);
    chk("t6_flush_busy", 32'(busy_o), 32'd0);
    chk("t6_flush_done", 32'(done_o), 32'd0);
    tick();
    chk("t6_flush_nodone", 32'(done_o), 32'd0);

    // Asynchronous reset mid-run, then a clean restart.
    do_start();
    beat("t7", 0, 9'h010, 2'd0, 1'b0);
    beat("t7", 1, 9'h011, 2'd0, 1'b0);
    #3;
    rst_i = 1'b0;
    #1;
    chk("t7_rst_valid", 32'(valid_o), 32'd0);
    chk("t7_rst_addr", 32'(addr_o), 32'd0);
    chk("t7_rst_busy", 32'(busy_o), 32'd0);
    chk("t7_rst_last", 32'(last_o), 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    tick();
    do_start();
    chk("t8_restart_valid", 32'(valid_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      beat("t8", i, 9'(9'h010 + i), 2'd0, 1'b0);
    end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("t8_end_busy", 32'(busy_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
